// File: rtl/ram_sync_arbiter_pkg.sv
// Shared types and default sizing for the two-requester ram_sync arbiter.
package ram_sync_arbiter_pkg;

    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 4;
    localparam int BURST_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

endpackage

// File: rtl/ram_sync_arb_pick.sv
// Combinational next-owner selection. Defining RAM_ARB_FIXED_PRIO_EN replaces
// round-robin/burst fairness with strict priority for requester A.
module ram_sync_arb_pick
    import ram_sync_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  state_e             state,
    input  logic               a_valid,
    input  logic               b_valid,
    input  logic [BURST_W-1:0] burst_cnt,
    input  owner_e             last_owner,
    output logic               grant_a,
    output logic               grant_b
);

    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_s;

    // Strict priority: B only sees the RAM when A is silent
    always_comb begin
        unused_s = ^{state, burst_cnt, last_owner, MAX_BURST_C};
        grant_a  = a_valid;
        grant_b  = b_valid & ~a_valid;
    end
`else
    // Round-robin with a burst cap that only bites while the other side waits
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    if (last_owner == OWNER_B) begin
                        grant_a = 1'b1;
                    end else begin
                        grant_b = 1'b1;
                    end
                end else if (a_valid) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b0;
                end
            end
            OWN_A: begin
                if (a_valid && (!b_valid || (burst_cnt < MAX_BURST_C))) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b0;
                end
            end
            OWN_B: begin
                if (b_valid && (!a_valid || (burst_cnt < MAX_BURST_C))) begin
                    grant_b = 1'b1;
                end else if (a_valid) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b0;
                end
            end
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase
    end
`endif

endmodule

// File: rtl/ram_sync_arbiter.sv
// Arbitrates one ram_sync port between requesters A and B and routes read data
// back to the issuer. RAM_ARB_FIXED_PRIO_EN selects strict A priority.
module ram_sync_arbiter
    import ram_sync_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_writeOn,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

    state_e             state_r;
    logic [BURST_W-1:0] burst_cnt_r;
    owner_e             last_owner_r;
    logic               pend_valid_r;
    owner_e             pend_owner_r;
    logic               grant_a_s;
    logic               grant_b_s;

    ram_sync_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .state      (state_r),
        .a_valid    (a_valid),
        .b_valid    (b_valid),
        .burst_cnt  (burst_cnt_r),
        .last_owner (last_owner_r),
        .grant_a    (grant_a_s),
        .grant_b    (grant_b_s)
    );

    // Grants are masked by reset so nothing reaches the RAM while it is held
    always_comb begin
        a_ready     = grant_a_s & ~reset;
        b_ready     = grant_b_s & ~reset;
        ram_writeOn = 1'b0;
        ram_address = '0;
        ram_data_in = '0;
        if (a_ready) begin
            ram_writeOn = a_we;
            ram_address = a_addr;
            ram_data_in = a_wdata;
        end else if (b_ready) begin
            ram_writeOn = b_we;
            ram_address = b_addr;
            ram_data_in = b_wdata;
        end else begin
            ram_writeOn = 1'b0;
        end
    end

    // Read data is only exposed in the single cycle the tag marks as valid
    always_comb begin
        a_rvalid = pend_valid_r & (pend_owner_r == OWNER_A);
        b_rvalid = pend_valid_r & (pend_owner_r == OWNER_B);
        a_rdata  = a_rvalid ? ram_data_out : '0;
        b_rdata  = b_rvalid ? ram_data_out : '0;
    end

    // Ownership FSM, burst counter and read-response tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            burst_cnt_r  <= {BURST_W{1'b0}};
            last_owner_r <= OWNER_B;
            pend_valid_r <= 1'b0;
            pend_owner_r <= OWNER_A;
        end else begin
            pend_valid_r <= (a_ready & ~a_we) | (b_ready & ~b_we);
            pend_owner_r <= b_ready ? OWNER_B : OWNER_A;
            case (state_r)
                IDLE: begin
                    if (grant_a_s) begin
                        state_r     <= OWN_A;
                        burst_cnt_r <= BURST_W'(1);
                    end else if (grant_b_s) begin
                        state_r     <= OWN_B;
                        burst_cnt_r <= BURST_W'(1);
                    end else begin
                        burst_cnt_r <= {BURST_W{1'b0}};
                    end
                end
                OWN_A: begin
                    if (grant_a_s) begin
                        if (burst_cnt_r < MAX_BURST_C) begin
                            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                        end
                    end else begin
                        state_r      <= grant_b_s ? OWN_B : IDLE;
                        burst_cnt_r  <= grant_b_s ? BURST_W'(1) : {BURST_W{1'b0}};
                        last_owner_r <= OWNER_A;
                    end
                end
                OWN_B: begin
                    if (grant_b_s) begin
                        if (burst_cnt_r < MAX_BURST_C) begin
                            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
                        end
                    end else begin
                        state_r      <= grant_a_s ? OWN_A : IDLE;
                        burst_cnt_r  <= grant_a_s ? BURST_W'(1) : {BURST_W{1'b0}};
                        last_owner_r <= OWNER_B;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    burst_cnt_r <= {BURST_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sync_arbiter.sv
// Directed table-driven bench for ram_sync_arbiter with a behavioural ram_sync.
module tb_ram_sync_arbiter;
    import ram_sync_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        a_valid, a_we, a_ready, a_rvalid;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_valid, b_we, b_ready, b_rvalid;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        ram_writeOn;
    logic [4:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    ram_sync_arbiter dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_writeOn(ram_writeOn), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data
    always @(posedge clk) begin
        if (ram_writeOn) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    typedef struct {
        logic av, aw; logic [4:0] aa; logic [31:0] ad;
        logic bv, bw; logic [4:0] ba; logic [31:0] bd;
        logic ea_rdy, eb_rdy;
        logic ea_rv;  logic [31:0] ea_rd;
        logic eb_rv;  logic [31:0] eb_rd;
        logic e_we;   logic [4:0] e_addr; logic [31:0] e_din;
    } vec_t;

    vec_t tbl [0:18];

    function automatic vec_t mk(
        input logic av, aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic bv, bw, input logic [4:0] ba, input logic [31:0] bd,
        input logic ea_rdy, eb_rdy,
        input logic ea_rv, input logic [31:0] ea_rd,
        input logic eb_rv, input logic [31:0] eb_rd,
        input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_din);
        vec_t v;
        v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
        v.bv = bv; v.bw = bw; v.ba = ba; v.bd = bd;
        v.ea_rdy = ea_rdy; v.eb_rdy = eb_rdy;
        v.ea_rv = ea_rv; v.ea_rd = ea_rd; v.eb_rv = eb_rv; v.eb_rd = eb_rd;
        v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din;
        return v;
    endfunction

    function automatic logic [31:0] m(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic exp_a, prev_a;
    logic [31:0] DB, ON;

    initial begin
        DB = 32'hDEAD_BEEF;
        ON = 32'h1111_1111;
        for (int i = 0; i < 32; i++) mem[i] = m(i);

        //        A: v w addr data       B: v w addr data   rdyA rdyB  A rv/rd        B rv/rd     we addr din
        tbl[0]  = mk(1'b0,1'b0,5'd0,32'd0,  1'b0,1'b0,5'd0,32'd0,   1'b0,1'b0, 1'b0,32'd0,  1'b0,32'd0, 1'b0,5'd0,32'd0);
        tbl[1]  = mk(1'b1,1'b1,5'd5,DB,     1'b0,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b0,32'd0,  1'b0,32'd0, 1'b1,5'd5,DB);
        tbl[2]  = mk(1'b1,1'b0,5'd5,32'd0,  1'b0,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b0,32'd0,  1'b0,32'd0, 1'b0,5'd5,32'd0);
        tbl[3]  = mk(1'b1,1'b1,5'd31,ON,    1'b1,1'b0,5'd31,32'd0,  1'b1,1'b0, 1'b1,DB,     1'b0,32'd0, 1'b1,5'd31,ON);
        tbl[4]  = mk(1'b0,1'b0,5'd0,32'd0,  1'b1,1'b0,5'd31,32'd0,  1'b0,1'b1, 1'b0,32'd0,  1'b0,32'd0, 1'b0,5'd31,32'd0);
        tbl[5]  = mk(1'b0,1'b0,5'd0,32'd0,  1'b0,1'b0,5'd0,32'd0,   1'b0,1'b0, 1'b0,32'd0,  1'b1,ON,    1'b0,5'd0,32'd0);
        tbl[6]  = mk(1'b1,1'b0,5'd0,32'd0,  1'b1,1'b0,5'd4,32'd0,   1'b1,1'b0, 1'b0,32'd0,  1'b0,32'd0, 1'b0,5'd0,32'd0);
        tbl[7]  = mk(1'b1,1'b0,5'd1,32'd0,  1'b1,1'b0,5'd4,32'd0,   1'b1,1'b0, 1'b1,m(0),   1'b0,32'd0, 1'b0,5'd1,32'd0);
        tbl[8]  = mk(1'b1,1'b0,5'd2,32'd0,  1'b1,1'b0,5'd4,32'd0,   1'b1,1'b0, 1'b1,m(1),   1'b0,32'd0, 1'b0,5'd2,32'd0);
        tbl[9]  = mk(1'b1,1'b0,5'd3,32'd0,  1'b1,1'b0,5'd4,32'd0,   1'b1,1'b0, 1'b1,m(2),   1'b0,32'd0, 1'b0,5'd3,32'd0);
        tbl[10] = mk(1'b1,1'b0,5'd4,32'd0,  1'b1,1'b0,5'd4,32'd0,   1'b0,1'b1, 1'b1,m(3),   1'b0,32'd0, 1'b0,5'd4,32'd0);
        tbl[11] = mk(1'b1,1'b0,5'd4,32'd0,  1'b1,1'b0,5'd5,32'd0,   1'b0,1'b1, 1'b0,32'd0,  1'b1,m(4),  1'b0,5'd5,32'd0);
        tbl[12] = mk(1'b1,1'b0,5'd4,32'd0,  1'b1,1'b0,5'd6,32'd0,   1'b0,1'b1, 1'b0,32'd0,  1'b1,DB,    1'b0,5'd6,32'd0);
        tbl[13] = mk(1'b1,1'b0,5'd4,32'd0,  1'b1,1'b0,5'd7,32'd0,   1'b0,1'b1, 1'b0,32'd0,  1'b1,m(6),  1'b0,5'd7,32'd0);
        tbl[14] = mk(1'b1,1'b0,5'd4,32'd0,  1'b1,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b0,32'd0,  1'b1,m(7),  1'b0,5'd4,32'd0);
        tbl[15] = mk(1'b1,1'b0,5'd5,32'd0,  1'b1,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b1,m(4),   1'b0,32'd0, 1'b0,5'd5,32'd0);
        tbl[16] = mk(1'b1,1'b0,5'd6,32'd0,  1'b1,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b1,DB,     1'b0,32'd0, 1'b0,5'd6,32'd0);
        tbl[17] = mk(1'b1,1'b0,5'd7,32'd0,  1'b1,1'b0,5'd0,32'd0,   1'b1,1'b0, 1'b1,m(6),   1'b0,32'd0, 1'b0,5'd7,32'd0);
        tbl[18] = mk(1'b0,1'b0,5'd0,32'd0,  1'b0,1'b0,5'd0,32'd0,   1'b0,1'b0, 1'b1,m(7),   1'b0,32'd0, 1'b0,5'd0,32'd0);

        // Reset held three cycles with both requesters asking (A writing)
        reset = 1'b1;
        a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = m(0);
        b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd0; b_wdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("rst%0d_a_ready", i), 32'(a_ready), 32'd0);
            check($sformatf("rst%0d_b_ready", i), 32'(b_ready), 32'd0);
            check($sformatf("rst%0d_rvalid", i), 32'({a_rvalid, b_rvalid}), 32'd0);
            check($sformatf("rst%0d_writeOn", i), 32'(ram_writeOn), 32'd0);
        end
        @(negedge clk); reset = 1'b0; #1;
        check("rel_a_ready", 32'(a_ready), 32'd1);
        check("rel_b_ready", 32'(b_ready), 32'd0);
        check("rel_writeOn", 32'(ram_writeOn), 32'd1);
        @(posedge clk); #1;
        check("rel_state", 32'(dut.state_r), 32'(OWN_A));

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            a_valid = tbl[i].av; a_we = tbl[i].aw; a_addr = tbl[i].aa; a_wdata = tbl[i].ad;
            b_valid = tbl[i].bv; b_we = tbl[i].bw; b_addr = tbl[i].ba; b_wdata = tbl[i].bd;
            #1;
            check($sformatf("r%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ea_rdy));
            check($sformatf("r%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].eb_rdy));
            check($sformatf("r%0d_a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].ea_rv));
            check($sformatf("r%0d_a_rdata", i), a_rdata, tbl[i].ea_rd);
            check($sformatf("r%0d_b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].eb_rv));
            check($sformatf("r%0d_b_rdata", i), b_rdata, tbl[i].eb_rd);
            check($sformatf("r%0d_writeOn", i), 32'(ram_writeOn), 32'(tbl[i].e_we));
            check($sformatf("r%0d_address", i), 32'(ram_address), 32'(tbl[i].e_addr));
            check($sformatf("r%0d_data_in", i), ram_data_in, tbl[i].e_din);
        end

        // Asynchronous reset pulse while an A read is in flight
        @(negedge clk);
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd1;
        #1;
        check("mid_a_ready", 32'(a_ready), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1; #1;
        check("mid_async_a_ready", 32'(a_ready), 32'd0);
        check("mid_async_a_rvalid", 32'(a_rvalid), 32'd0);
        a_valid = 1'b0; #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("mid_n1_a_rvalid", 32'(a_rvalid), 32'd0);
        check("mid_state", 32'(dut.state_r), 32'(IDLE));
        @(negedge clk); #1;
        check("mid_n2_a_rvalid", 32'(a_rvalid), 32'd0);

        // Both requesters valid for ten cycles, then A drops out
        prev_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd2;
            b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd3;
            #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = ((i / 4) % 2) == 0;
`endif
            check($sformatf("c%0d_a_ready", i), 32'(a_ready), 32'(exp_a));
            check($sformatf("c%0d_b_ready", i), 32'(b_ready), 32'(!exp_a));
            check($sformatf("c%0d_a_rvalid", i), 32'(a_rvalid), 32'(i > 0 && prev_a));
            check($sformatf("c%0d_b_rvalid", i), 32'(b_rvalid), 32'(i > 0 && !prev_a));
            check($sformatf("c%0d_rdata", i), a_rdata | b_rdata,
                  (i == 0) ? 32'd0 : (prev_a ? m(2) : m(3)));
            prev_a = exp_a;
        end
        @(negedge clk);
        a_valid = 1'b0; #1;
        check("drop_b_ready", 32'(b_ready), 32'd1);
        check("drop_a_ready", 32'(a_ready), 32'd0);
        check("drop_a_rvalid", 32'(a_rvalid), 32'(prev_a));
        @(negedge clk);
        b_valid = 1'b0; #1;
        check("end_b_rvalid", 32'(b_rvalid), 32'd1);
        check("end_b_rdata", b_rdata, m(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sync_arbiter.md
Name: ram_sync_arbiter

Overview:
- Shares one synchronous single-port RAM (32 words x 32 bits, 5-bit address, writeOn strobe, 1-cycle read latency) between two requesters, A and B.
- Round-robin arbitration with a bounded burst counter, so a requester that keeps asserting valid cannot starve the other.
- Drives the RAM port directly and routes read data back to the requester that issued the read.
- Sits between the datapath requesters and the existing ram_sync instance.

Parameters:
- ADDR_W, 5, RAM address width (depth = 2**ADDR_W = 32).
- DATA_W, 32, RAM word width.
- MAX_BURST, 4, maximum consecutive accepted transfers for one owner while the other requester is waiting; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a transfer pending.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_ready  out  1  A transfer accepted this cycle (a_valid & a_ready).
- a_rvalid  out  1  A read data valid (1-cycle pulse).
- a_rdata  out  DATA_W  A read data.
- b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as A, for requester B.
- ram_writeOn  out  1  to RAM writeOn.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM data_in.
- ram_data_out  in  DATA_W  from RAM data_out; registered inside the RAM, valid 1 cycle after the read was presented.

Behaviour:
- FSM states:
  - IDLE: no owner.
  - OWN_A: A owns the RAM.
  - OWN_B: B owns the RAM.
  - Reset state is IDLE, with burst_cnt = 0 and last_owner = B, so A wins the first tie.
- Grant is combinational from state and the valids; the RAM port is muxed combinationally from the granted requester.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_owner.
  - Next state is OWN_x for the granted requester; burst_cnt = 1.
- OWN_x:
  - x is re-granted if x_valid and (other not valid, or burst_cnt < MAX_BURST); burst_cnt increments, saturating at MAX_BURST.
  - Otherwise, if the other requester is valid, it is granted; state switches, burst_cnt = 1, last_owner = x.
  - If neither is valid: go to IDLE, last_owner = x, burst_cnt = 0.
- At most one of a_ready and b_ready is high in any cycle; ready is never high without the matching valid.
- When a transfer is accepted:
  - ram_address = granted addr.
  - ram_writeOn = granted we.
  - ram_data_in = granted wdata.
- When no transfer is accepted: ram_writeOn = 0, ram_address = 0, ram_data_in = 0.
- Read response:
  - A read accepted in cycle N sets a registered pending tag (valid + owner).
  - In cycle N+1, x_rvalid = 1 for exactly that cycle and x_rdata = ram_data_out.
  - Outside that cycle, x_rdata is held at 0.
- Writes produce no response.
- Back-to-back reads (one per cycle) give rvalid on consecutive cycles, in acceptance order.
- A read of an address written in the previous cycle returns the new data.
- A request (valid + fields) must stay stable until ready; the arbiter does not latch requests.
- Reset asserted at any time:
  - Immediately (asynchronously): state to IDLE, burst_cnt to 0, pending tag cleared, a_rvalid = b_rvalid = 0, both readies = 0, ram_writeOn = 0.
  - A read that was in flight is dropped; no rvalid is produced after reset.
- Reset values of all outputs are 0.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: A has strict priority. B is granted only when a_valid = 0; MAX_BURST and last_owner are ignored, and B can starve.
- Undefined (default): the round-robin/burst behaviour above.

Decomposition:
- Package ram_sync_arbiter_pkg holds:
  - the state enum (IDLE, OWN_A, OWN_B);
  - an owner encoding (OWNER_A = 0, OWNER_B = 1);
  - default constants for ADDR_W, DATA_W and MAX_BURST.
- One sub-module, ram_sync_arb_pick: purely combinational next-owner selection from state, valids, burst_cnt and last_owner. It contains the RAM_ARB_FIXED_PRIO_EN variant.
- The top level holds the FSM registers, burst counter, response tag and RAM port mux.

Test Plan:
- Reset: hold reset 3 cycles with both valids = 1 -> readies, rvalids and ram_writeOn all 0. Release -> A granted first; state OWN_A.
- Single requester: A writes 0xDEADBEEF to addr 5, then reads addr 5 the next cycle -> a_rvalid pulses 1 cycle after the read is accepted, a_rdata = 0xDEADBEEF, b_rvalid stays 0.
- Contention, MAX_BURST = 4, both valid continuously with reads to addrs 0..7 -> grant pattern AAAABBBBAAAA; every rvalid lands on the issuer, 1 cycle after its accept.
- Write/read separation: A writes 0x11111111 to addr 31 while B waits, then B reads addr 31 -> b_rdata = 0x11111111; no A rvalid is generated by B's read.
- Mid-operation reset: A read accepted at cycle N, reset pulsed asynchronously between N and N+1 -> no a_rvalid at N+1; state IDLE after reset.
- With RAM_ARB_FIXED_PRIO_EN defined and both valid for 10 cycles -> a_ready = 1 on all 10 cycles, b_ready = 0; drop a_valid -> b_ready = 1 the same cycle.
